// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_ctrl_pkg
//  Purpose  : Shared types and constants for the divider sequencing
//             controller and its HI/LO register file.
//  Contents : state_t (IDLE/LAUNCH/RUN), DIV_W, DIV_LATENCY, DIV_ZERO_LO
//  Revision : 1.0 - initial release
// ============================================================================
package div_ctrl_pkg;

   localparam int DIV_W       = 32;
   // Cycles from DIV acceptance edge to the HI/LO capture edge.
   localparam int DIV_LATENCY = 33;
   // LO value produced for a divide-by-zero when the bypass is built in.
   localparam logic [DIV_W-1:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

endpackage : div_ctrl_pkg
`default_nettype wire

// File: rtl/div_ctrl_hilo_regs.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_regs
//  Purpose  : Architectural HI/LO register pair with write-select muxing.
//  Ports    : clk_i, rst_ni         - clock, async active-low reset
//             div_we_i, div_q_i,
//             div_r_i               - division result write (LO<=q, HI<=r)
//             byp_we_i, byp_hi_i    - divide-by-zero bypass write
//                                     (LO<=DIV_ZERO_LO, HI<=byp_hi_i)
//             mthi_we_i, mtlo_we_i,
//             mt_data_i             - move-to-HI/LO writes
//             hi_o, lo_o            - register outputs
//  Revision : 1.0 - initial release
// ============================================================================
module hilo_regs
   import div_ctrl_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] HILO_RST = '0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              div_we_i,
   input  logic [DATA_W-1:0] div_q_i,
   input  logic [DATA_W-1:0] div_r_i,
   input  logic              byp_we_i,
   input  logic [DATA_W-1:0] byp_hi_i,
   input  logic              mthi_we_i,
   input  logic              mtlo_we_i,
   input  logic [DATA_W-1:0] mt_data_i,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;

   // The controller guarantees the three sources are mutually exclusive;
   // the priority order below only matters if that ever changes.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (div_we_i) begin
         hi_d = div_r_i;
         lo_d = div_q_i;
      end else if (byp_we_i) begin
         hi_d = byp_hi_i;
         lo_d = DIV_ZERO_LO;
      end else begin
         if (mthi_we_i) hi_d = mt_data_i;
         if (mtlo_we_i) lo_d = mt_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hi_q <= HILO_RST;
         lo_q <= HILO_RST;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule : hilo_regs
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_ctrl
//  Purpose  : Sequencing controller for the 32-bit iterative signed divider
//             and owner of HI/LO. Launches the negedge-clocked divider,
//             holds its operands for the whole run, captures q/r into LO/HI,
//             serves MTHI/MTLO and stalls HI/LO instructions while busy.
//  Ports    : clk_i, rst_ni              - clock, async active-low reset
//             hilo_op_i, div_req_i       - EX instruction class
//             op_a_i, op_b_i             - dividend / divisor
//             mthi_we_i, mtlo_we_i,
//             mt_data_i                  - move-to-HI/LO
//             flush_i                    - squash of the EX instruction
//             stall_o                    - hold HI/LO instruction in EX
//             hi_o, lo_o                 - architectural HI/LO
//             done_o                     - one-cycle division-complete pulse
//             div_dividend_o,
//             div_divisor_o, div_start_o - divider launch interface
//             div_busy_i, div_q_i,
//             div_r_i                    - divider status / results
//  Config   : DIV_ZERO_BYPASS_EN - divide-by-zero resolved in IDLE without
//             launching the divider (LO<=all-ones, HI<=dividend).
//  Revision : 1.0 - initial release
// ============================================================================
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] HILO_RST = 32'h0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              hilo_op_i,
   input  logic              div_req_i,
   input  logic [DATA_W-1:0] op_a_i,
   input  logic [DATA_W-1:0] op_b_i,
   input  logic              mthi_we_i,
   input  logic              mtlo_we_i,
   input  logic [DATA_W-1:0] mt_data_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic              done_o,
   output logic [DATA_W-1:0] div_dividend_o,
   output logic [DATA_W-1:0] div_divisor_o,
   output logic              div_start_o,
   input  logic              div_busy_i,
   input  logic [DATA_W-1:0] div_q_i,
   input  logic [DATA_W-1:0] div_r_i
);

   state_t            state_q;
   logic              cancel_q;
   logic              done_q;
   logic              div_start_q;
   logic [DATA_W-1:0] dividend_q;
   logic [DATA_W-1:0] divisor_q;

   logic w_idle;
   logic w_accept;
   logic w_byp;
   logic w_div_we;
   logic w_mt_ok;

   assign w_idle   = (state_q == ST_IDLE);
   assign w_accept = w_idle & div_req_i & hilo_op_i & ~flush_i;

`ifdef DIV_ZERO_BYPASS_EN
   assign w_byp = w_accept & (op_b_i == '0);
`else
   assign w_byp = 1'b0;
`endif

   // A flush landing on the capture edge squashes the result as well.
   assign w_div_we = (state_q == ST_RUN) & ~div_busy_i & ~cancel_q & ~flush_i;
   // MT is only honoured in IDLE; elsewhere the pipeline is stalled and
   // re-presents the instruction later.
   assign w_mt_ok  = w_idle & ~flush_i & ~w_accept;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         cancel_q    <= 1'b0;
         done_q      <= 1'b0;
         div_start_q <= 1'b0;
         dividend_q  <= '0;
         divisor_q   <= '0;
      end else begin
         div_start_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (w_byp) begin
                  done_q <= 1'b1;
               end else if (w_accept) begin
                  // Operands stay frozen until the next acceptance; the
                  // divider's sign fix-up reads them combinationally.
                  dividend_q  <= op_a_i;
                  divisor_q   <= op_b_i;
                  div_start_q <= 1'b1;
                  cancel_q    <= 1'b0;
                  state_q     <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               if (flush_i)    cancel_q <= 1'b1;
               if (div_busy_i) state_q  <= ST_RUN;
            end
            ST_RUN: begin
               if (!div_busy_i) begin
                  done_q  <= ~(cancel_q | flush_i);
                  state_q <= ST_IDLE;
               end else if (flush_i) begin
                  cancel_q <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   hilo_regs #(
      .DATA_W   (DATA_W),
      .HILO_RST (HILO_RST)
   ) u_hilo_regs (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .div_we_i  (w_div_we),
      .div_q_i   (div_q_i),
      .div_r_i   (div_r_i),
      .byp_we_i  (w_byp),
      .byp_hi_i  (op_a_i),
      .mthi_we_i (mthi_we_i & w_mt_ok),
      .mtlo_we_i (mtlo_we_i & w_mt_ok),
      .mt_data_i (mt_data_i),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   assign stall_o        = hilo_op_i & ~w_idle;
   assign done_o         = done_q;
   assign div_start_o    = div_start_q;
   assign div_dividend_o = dividend_q;
   assign div_divisor_o  = divisor_q;

endmodule : div_ctrl
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_ctrl
//  Purpose  : Self-checking bench for div_ctrl. Contains a negedge-clocked
//             behavioural divider, a plain-arithmetic signed reference and a
//             scoreboard of expected division completions.
//  Config   : honours DIV_ZERO_BYPASS_EN like the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hilo_op = 1'b0, div_req = 1'b0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        mthi_we = 1'b0, mtlo_we = 1'b0;
   logic [31:0] mt_data = '0;
   logic        flush = 1'b0;
   logic        stall_o, done_o, div_start_o;
   logic [31:0] hi_o, lo_o, div_dividend_o, div_divisor_o;
   logic        div_busy = 1'b0;
   logic [31:0] div_q = '0, div_r = '0;
   int          div_cnt = 0;

   int          total = 0, passed = 0, cyc = 0;
   logic [63:0] exp_q[$];
   int          exp_t[$];
   logic [31:0] model_hi = '0, model_lo = '0;

   div_ctrl #(.DATA_W(32), .HILO_RST(32'h0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .hilo_op_i(hilo_op), .div_req_i(div_req),
      .op_a_i(op_a), .op_b_i(op_b), .mthi_we_i(mthi_we), .mtlo_we_i(mtlo_we),
      .mt_data_i(mt_data), .flush_i(flush), .stall_o(stall_o), .hi_o(hi_o),
      .lo_o(lo_o), .done_o(done_o), .div_dividend_o(div_dividend_o),
      .div_divisor_o(div_divisor_o), .div_start_o(div_start_o),
      .div_busy_i(div_busy), .div_q_i(div_q), .div_r_i(div_r)
   );

   always #5 clk = ~clk;

   // Signed division, truncating toward zero; divide-by-zero yields
   // q = all ones, r = dividend.
   function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
      longint sa, sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else begin
         sa = $signed(a);
         sb = $signed(b);
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end
   endfunction

   // Divider: samples start on a negedge, then 32 negedge iterations.
   // Results are garbage until busy falls, and are computed from the
   // operand outputs at the very end so any operand drift is visible.
   always @(negedge clk or negedge rst_n) begin
      logic [31:0] q, r;
      if (!rst_n) begin
         div_busy <= 1'b0;
         div_cnt  <= 0;
      end else if (!div_busy) begin
         if (div_start_o) begin
            div_busy <= 1'b1;
            div_cnt  <= 32;
            div_q    <= $urandom;
            div_r    <= $urandom;
         end
      end else begin
         if (div_cnt == 1) begin
            ref_div(div_dividend_o, div_divisor_o, q, r);
            div_q    <= q;
            div_r    <= r;
            div_busy <= 1'b0;
         end
         div_cnt <= div_cnt - 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: pops the scoreboard whenever done pulses.
   initial begin
      logic [63:0] e;
      int          t;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL done_spurious: done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
               e = exp_q.pop_front();
               t = exp_t.pop_front();
               check("done_hi", hi_o, e[63:32]);
               check("done_lo", lo_o, e[31:0]);
               check("done_cycle", 32'(cyc), 32'(t));
            end
         end
      end
   end

   task automatic mt_write(input bit to_hi, input logic [31:0] d, input bit fl);
      @(negedge clk);
      hilo_op = 1'b1; mthi_we = to_hi; mtlo_we = ~to_hi; mt_data = d; flush = fl;
      @(negedge clk);
      hilo_op = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; flush = 1'b0;
      if (!fl) begin
         if (to_hi) model_hi = d; else model_lo = d;
      end
      check(fl ? "mt_flush_hi" : "mt_hi", hi_o, model_hi);
      check(fl ? "mt_flush_lo" : "mt_lo", lo_o, model_lo);
   endtask

   // One DIV. flush_at / mt_at / rst_at give the negedge index i (T(i+0.5))
   // at which to flush, present MTLO 0x1234, or assert reset; -1 = never.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int mt_at, input int rst_at);
      bit          byp, stall_ok;
      logic [31:0] eq, er;
      int          issue;
      byp = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      byp = (b == 32'd0);
      if (byp) begin
         eq = 32'hFFFF_FFFF;
         er = a;
      end else
`endif
      ref_div(a, b, eq, er);
      @(negedge clk);
      hilo_op = 1'b1; div_req = 1'b1; op_a = a; op_b = b;
      issue = cyc;
      if (flush_at < 0 && rst_at < 0) begin
         exp_q.push_back({er, eq});
         exp_t.push_back(issue + 1 + (byp ? 0 : 33));
         model_hi = er;
         model_lo = eq;
      end
      @(negedge clk);
      div_req = 1'b0; op_a = $urandom; op_b = $urandom;
      if (byp) begin
         check("byp_no_start", {31'd0, div_start_o}, 32'd0);
         check("byp_no_stall", {31'd0, stall_o}, 32'd0);
         check("byp_hi", hi_o, model_hi);
         check("byp_lo", lo_o, model_lo);
         hilo_op = 1'b0;
         return;
      end
      check("start_pulse", {31'd0, div_start_o}, 32'd1);
      stall_ok = 1'b1;
      for (int i = 0; i <= 32; i++) begin
         if (i > 0) @(negedge clk);
         flush = (i == flush_at);
         if (i == mt_at) begin mtlo_we = 1'b1; mt_data = 32'h1234; end
         if (i == 1) check("start_once", {31'd0, div_start_o}, 32'd0);
         if (i == rst_at) begin
            rst_n = 1'b0;
            #1;
            check("rst_run_hi", hi_o, 32'h0);
            check("rst_run_lo", lo_o, 32'h0);
            check("rst_run_stall", {31'd0, stall_o}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1; hilo_op = 1'b0; mtlo_we = 1'b0; flush = 1'b0;
            model_hi = '0; model_lo = '0;
            return;
         end
         if (stall_o !== 1'b1) stall_ok = 1'b0;
      end
      @(negedge clk);
      flush = 1'b0;
      check("stall_run", {31'd0, stall_ok}, 32'd1);
      check("stall_idle", {31'd0, stall_o}, 32'd0);
      check("end_hi", hi_o, model_hi);
      check("end_lo", lo_o, model_lo);
      if (mt_at >= 0) begin
         @(negedge clk);
         mtlo_we = 1'b0;
         model_lo = 32'h1234;
         check("mt_after_run_lo", lo_o, model_lo);
      end
      hilo_op = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      hilo_op = 1'b1;
      #1;
      check("rst_hi", hi_o, 32'h0);
      check("rst_lo", lo_o, 32'h0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_start", {31'd0, div_start_o}, 32'd0);
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      check("rst_dividend", div_dividend_o, 32'h0);
      check("rst_divisor", div_divisor_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1; hilo_op = 1'b0;

      mt_write(1'b1, 32'hA5A5_0001, 1'b0);
      mt_write(1'b0, 32'h5A5A_0002, 1'b0);
      mt_write(1'b1, 32'hDEAD_BEEF, 1'b1);

      // flush in IDLE blocks DIV acceptance
      @(negedge clk);
      hilo_op = 1'b1; div_req = 1'b1; op_a = 32'd50; op_b = 32'd5; flush = 1'b1;
      @(negedge clk);
      div_req = 1'b0; flush = 1'b0;
      check("flush_idle_start", {31'd0, div_start_o}, 32'd0);
      check("flush_idle_stall", {31'd0, stall_o}, 32'd0);
      hilo_op = 1'b0;

      run_div(32'd100, 32'd7, -1, -1, -1);
      run_div(-32'sd100, 32'd7, -1, -1, -1);
      run_div(32'd100, -32'sd7, -1, -1, -1);
      run_div(32'd100, 32'd7, 9, -1, -1);
      run_div(32'd100, 32'd7, 0, -1, -1);
      run_div(32'h7FFF_0000, 32'd3, -1, 5, -1);
      run_div(32'd5, 32'd0, -1, -1, -1);
      run_div(32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
      run_div(32'h1234_5678, 32'd1000, -1, -1, 14);
      run_div(32'd9, 32'd3, -1, -1, -1);
      for (int k = 0; k < 8; k++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = ($urandom_range(0, 1) == 1) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
         run_div(ra, rb, -1, -1, -1);
      end

      repeat (4) @(negedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
      $fatal(1);
   end

endmodule : tb_div_ctrl
`default_nettype wire
